// File: rtl/lock_timer_pkg.sv
// Shared types and constants for the lock cycle timer.
// The optional pause feature is enabled by defining LOCK_TIMER_PAUSE_EN.
package lock_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARRIVE = 3'd1,
        ST_FANDP  = 3'd2,
        ST_EVAC   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam int unsigned ARRIVE_W   = 3;
    localparam int unsigned FANDP_W    = 3;
    localparam int unsigned EVAC_W     = 4;

    localparam int unsigned ARRIVE_MAX = 4;
    localparam int unsigned FANDP_MAX  = 7;
    localparam int unsigned EVAC_MAX   = 8;

    // The three timed phases; the prescaler only runs while in one of them.
    function automatic logic is_active(input state_e s);
        return (s == ST_ARRIVE) || (s == ST_FANDP) || (s == ST_EVAC);
    endfunction

endpackage

// File: rtl/lock_timer_tick.sv
// Prescaler for the lock timer: divides Clock by TICK_DIV while enabled.
// clear has priority over enable; tick marks the last cycle of each period.
module lock_timer_tick #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
        end
    end

    // Gated so a frozen prescaler sitting on LAST cannot advance the phases.
    assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/lock_timer.sv
// Lock cycle sequencer: ARRIVE -> FANDP -> EVAC -> DONE, each step one prescaler tick.
// Define LOCK_TIMER_PAUSE_EN to add the pause input that freezes the running phase.
module lock_timer
    import lock_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                start,
    input  logic                abort,
`ifdef LOCK_TIMER_PAUSE_EN
    input  logic                pause,
`endif
    output logic [ARRIVE_W-1:0] countArrive,
    output logic [FANDP_W-1:0]  countFandP,
    output logic [EVAC_W-1:0]   countEvacuate,
    output logic                busy,
    output logic                done
);

    state_e              state_q, state_d;
    logic [ARRIVE_W-1:0] arr_q, arr_d;
    logic [FANDP_W-1:0]  fandp_q, fandp_d;
    logic [EVAC_W-1:0]   evac_q, evac_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic run_en;
    logic presc_clear;
    logic tick;

`ifdef LOCK_TIMER_PAUSE_EN
    assign run_en = is_active(state_q) && !pause;
`else
    assign run_en = is_active(state_q);
`endif

    // Every state change (including abort) restarts the prescaler from zero.
    assign presc_clear = abort || (state_d != state_q);

    lock_timer_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .Clock  (Clock),
        .Reset  (Reset),
        .clear  (presc_clear),
        .enable (run_en),
        .tick   (tick)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            arr_q   <= '0;
            fandp_q <= '0;
            evac_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            arr_q   <= arr_d;
            fandp_q <= fandp_d;
            evac_q  <= evac_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        arr_d   = arr_q;
        fandp_d = fandp_q;
        evac_d  = evac_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            arr_d   = '0;
            fandp_d = '0;
            evac_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_ARRIVE;
                        arr_d   = '0;
                        fandp_d = '0;
                        evac_d  = '0;
                    end
                end
                ST_ARRIVE: begin
                    if (tick) begin
                        if (arr_q == ARRIVE_W'(ARRIVE_MAX)) begin
                            state_d = ST_FANDP;
                        end else begin
                            arr_d = arr_q + ARRIVE_W'(1);
                        end
                    end
                end
                ST_FANDP: begin
                    if (tick) begin
                        if (fandp_q == FANDP_W'(FANDP_MAX)) begin
                            state_d = ST_EVAC;
                        end else begin
                            fandp_d = fandp_q + FANDP_W'(1);
                        end
                    end
                end
                ST_EVAC: begin
                    if (tick) begin
                        if (evac_q == EVAC_W'(EVAC_MAX)) begin
                            state_d = ST_DONE;
                        end else begin
                            evac_d = evac_q + EVAC_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Status flags are registered from the upcoming state so they align with it.
        busy_d = is_active(state_d);
        done_d = (state_d == ST_DONE);
    end

    assign countArrive   = arr_q;
    assign countFandP    = fandp_q;
    assign countEvacuate = evac_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_lock_timer.sv
// Directed bench for lock_timer with TICK_DIV=4; phase edges counted from ARRIVE entry.
// Pause scenario is compiled in only when LOCK_TIMER_PAUSE_EN is defined.
module tb_lock_timer;

    logic       Clock;
    logic       Reset;
    logic       start;
    logic       abort;
    logic       pause;
    logic [2:0] countArrive;
    logic [2:0] countFandP;
    logic [3:0] countEvacuate;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    lock_timer #(.TICK_DIV(4)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .start         (start),
        .abort         (abort),
`ifdef LOCK_TIMER_PAUSE_EN
        .pause         (pause),
`endif
        .countArrive   (countArrive),
        .countFandP    (countFandP),
        .countEvacuate (countEvacuate),
        .busy          (busy),
        .done          (done)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Advance n cycles, landing on a falling edge.
    task automatic adv(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // One-cycle start pulse; returns at the first falling edge after ARRIVE entry (E0).
    task automatic pulse_start();
        start = 1'b1;
        adv(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0;
        #2;
        checks += 5;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        if (countArrive !== 3'd0) begin errors++; $display("FAIL reset_arr got=%0d exp=0", countArrive); end
        if (countFandP !== 3'd0) begin errors++; $display("FAIL reset_fandp got=%0d exp=0", countFandP); end
        if (countEvacuate !== 4'd0) begin errors++; $display("FAIL reset_evac got=%0d exp=0", countEvacuate); end
        adv(2);
        Reset = 1'b1;
        adv(2);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_full_run();
        pulse_start();
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL run_busy_e0 got=%b exp=1", busy); end
        if (countArrive !== 3'd0) begin errors++; $display("FAIL run_arr_e0 got=%0d exp=0", countArrive); end
        adv(4);   // E4
        checks++;
        if (countArrive !== 3'd1) begin errors++; $display("FAIL run_arr_e4 got=%0d exp=1", countArrive); end
        adv(11);  // E15
        checks++;
        if (countArrive !== 3'd3) begin errors++; $display("FAIL run_arr_e15 got=%0d exp=3", countArrive); end
        adv(1);   // E16
        checks++;
        if (countArrive !== 3'd4) begin errors++; $display("FAIL run_arr_e16 got=%0d exp=4", countArrive); end
        adv(4);   // E20: FANDP entered
        checks += 3;
        if (countArrive !== 3'd4) begin errors++; $display("FAIL run_arr_hold got=%0d exp=4", countArrive); end
        if (countFandP !== 3'd0) begin errors++; $display("FAIL run_fandp_e20 got=%0d exp=0", countFandP); end
        if (busy !== 1'b1) begin errors++; $display("FAIL run_busy_e20 got=%b exp=1", busy); end
        adv(4);   // E24
        checks++;
        if (countFandP !== 3'd1) begin errors++; $display("FAIL run_fandp_e24 got=%0d exp=1", countFandP); end
        adv(63);  // E87
        checks += 3;
        if (done !== 1'b0) begin errors++; $display("FAIL run_done_e87 got=%b exp=0", done); end
        if (busy !== 1'b1) begin errors++; $display("FAIL run_busy_e87 got=%b exp=1", busy); end
        if (countEvacuate !== 4'd8) begin errors++; $display("FAIL run_evac_e87 got=%0d exp=8", countEvacuate); end
        adv(1);   // E88: DONE
        checks += 5;
        if (done !== 1'b1) begin errors++; $display("FAIL run_done_e88 got=%b exp=1", done); end
        if (busy !== 1'b0) begin errors++; $display("FAIL run_busy_e88 got=%b exp=0", busy); end
        if (countArrive !== 3'd4) begin errors++; $display("FAIL run_final_arr got=%0d exp=4", countArrive); end
        if (countFandP !== 3'd7) begin errors++; $display("FAIL run_final_fandp got=%0d exp=7", countFandP); end
        if (countEvacuate !== 4'd8) begin errors++; $display("FAIL run_final_evac got=%0d exp=8", countEvacuate); end
        adv(1);   // E89: IDLE
        checks += 3;
        if (done !== 1'b0) begin errors++; $display("FAIL run_done_e89 got=%b exp=0", done); end
        if (busy !== 1'b0) begin errors++; $display("FAIL run_busy_e89 got=%b exp=0", busy); end
        if (countEvacuate !== 4'd8) begin errors++; $display("FAIL run_evac_hold got=%0d exp=8", countEvacuate); end
        adv(3);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL run_stays_idle got=%b exp=0", busy); end
    endtask

    task automatic test_abort();
        pulse_start();
        adv(33);  // E33: FANDP with countFandP=3
        checks++;
        if (countFandP !== 3'd3) begin errors++; $display("FAIL abort_pre_fandp got=%0d exp=3", countFandP); end
        abort = 1'b1;
        adv(1);
        abort = 1'b0;
        checks += 5;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
        if (countArrive !== 3'd0) begin errors++; $display("FAIL abort_arr got=%0d exp=0", countArrive); end
        if (countFandP !== 3'd0) begin errors++; $display("FAIL abort_fandp got=%0d exp=0", countFandP); end
        if (countEvacuate !== 4'd0) begin errors++; $display("FAIL abort_evac got=%0d exp=0", countEvacuate); end
        adv(2);
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_stays_idle got=%b exp=0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done got=%b exp=0", done); end
    endtask

    task automatic test_abort_start_idle();
        abort = 1'b1;
        start = 1'b1;
        adv(1);
        abort = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_busy got=%b exp=0", busy); end
        adv(2);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_idle got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        adv(73);  // E73: EVAC with countEvacuate=5
        checks++;
        if (countEvacuate !== 4'd5) begin errors++; $display("FAIL rmid_pre_evac got=%0d exp=5", countEvacuate); end
        #2 Reset = 1'b0;
        #1;
        checks += 5;
        if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL rmid_done got=%b exp=0", done); end
        if (countArrive !== 3'd0) begin errors++; $display("FAIL rmid_arr got=%0d exp=0", countArrive); end
        if (countFandP !== 3'd0) begin errors++; $display("FAIL rmid_fandp got=%0d exp=0", countFandP); end
        if (countEvacuate !== 4'd0) begin errors++; $display("FAIL rmid_evac got=%0d exp=0", countEvacuate); end
        adv(2);
        Reset = 1'b1;
        adv(6);
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL rmid_release_busy got=%b exp=0", busy); end
        if (countEvacuate !== 4'd0) begin errors++; $display("FAIL rmid_release_evac got=%0d exp=0", countEvacuate); end
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        adv(1);   // E0, start stays high
        adv(87);  // E87
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_e87 got=%b exp=1", busy); end
        adv(1);   // E88: DONE
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got=%b exp=1", done); end
        adv(1);   // E89: IDLE, held start sampled here
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got=%b exp=0", busy); end
        if (countFandP !== 3'd7) begin errors++; $display("FAIL b2b_idle_fandp got=%0d exp=7", countFandP); end
        adv(1);   // E90: new run
        checks += 5;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy got=%b exp=1", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL b2b_restart_done got=%b exp=0", done); end
        if (countArrive !== 3'd0) begin errors++; $display("FAIL b2b_arr got=%0d exp=0", countArrive); end
        if (countFandP !== 3'd0) begin errors++; $display("FAIL b2b_fandp got=%0d exp=0", countFandP); end
        if (countEvacuate !== 4'd0) begin errors++; $display("FAIL b2b_evac got=%0d exp=0", countEvacuate); end
        adv(4);
        checks++;
        if (countArrive !== 3'd1) begin errors++; $display("FAIL b2b_arr_tick got=%0d exp=1", countArrive); end
        start = 1'b0;
        abort = 1'b1;
        adv(1);
        abort = 1'b0;
        adv(1);
    endtask

`ifdef LOCK_TIMER_PAUSE_EN
    task automatic test_pause();
        pulse_start();
        adv(5);   // E5
        pause = 1'b1;
        adv(10);
        pause = 1'b0;
        checks++;
        if (countArrive !== 3'd1) begin errors++; $display("FAIL pause_frozen_arr got=%0d exp=1", countArrive); end
        adv(82);  // E97
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL pause_done_e97 got=%b exp=0", done); end
        adv(1);   // E98
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL pause_done_e98 got=%b exp=1", done); end
        adv(2);
    endtask
`endif

    initial begin
        test_reset();
        test_full_run();
        test_abort();
        test_abort_start_idle();
        test_reset_mid();
        test_back_to_back();
`ifdef LOCK_TIMER_PAUSE_EN
        test_pause();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lock_timer.md
LOCK_TIMER -- requirements
Module: lock_timer

Interface
REQ-001 Parameter: TICK_DIV, default 50000000, number of Clock cycles per count step; legal range 2 and above.
REQ-002 Port: Clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: Reset  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to begin a lock cycle; sampled only in IDLE.
REQ-005 Port: abort  input  1  return to IDLE immediately and clear all counts; highest priority after Reset.
REQ-006 Port: pause  input  1  freeze the prescaler and counts; present only with LOCK_TIMER_PAUSE_EN.
REQ-007 Port: countArrive  output  3  arrival phase step, 0..4.
REQ-008 Port: countFandP  output  3  fill-and-pump phase step, 0..7.
REQ-009 Port: countEvacuate  output  4  evacuation phase step, 0..8.
REQ-010 Port: busy  output  1  high in the ARRIVE, FANDP and EVAC states.
REQ-011 Port: done  output  1  one-cycle pulse on completion.

Function
REQ-012 The state machine SHALL have five states: IDLE, ARRIVE, FANDP, EVAC and DONE.
REQ-013 Prescaler: counts 0..TICK_DIV-1 only in active states; clears to 0 on every state entry; tick = (prescaler == TICK_DIV-1).
REQ-014 IDLE with start=1: next state ARRIVE; all counts cleared to 0 on the same edge; busy=1 from the next cycle.
REQ-015 Start behaviour: start in any non-IDLE state SHALL be ignored; a held start SHALL re-trigger only after the machine returns to IDLE.
REQ-016 ARRIVE on tick: if countArrive<4, increment countArrive; if countArrive==4, go to FANDP.
REQ-017 FANDP on tick: if countFandP<7, increment countFandP; if countFandP==7, go to EVAC.
REQ-018 EVAC on tick: if countEvacuate<8, increment countEvacuate; if countEvacuate==8, go to DONE.
REQ-019 Phase durations: ARRIVE 5*TICK_DIV cycles, FANDP 8*TICK_DIV cycles, EVAC 9*TICK_DIV cycles.
REQ-020 Completed counts: a finished phase's count SHALL hold its maximum value until the next accepted start or abort.
REQ-021 DONE: lasts exactly one cycle with done=1 and busy=0, then goes to IDLE.
REQ-022 Abort in any state: next state IDLE; all counts and the prescaler cleared to 0; done not asserted.
REQ-023 Abort and tick in the same cycle: abort wins.
REQ-024 Abort and start in IDLE in the same cycle: abort wins and the machine stays in IDLE.
REQ-025 Count range: no count SHALL wrap or exceed its maximum; output width is never overflowed.

Reset
REQ-026 Reset=0 SHALL asynchronously force: state IDLE, prescaler 0, all counts 0, busy 0, done 0.
REQ-027 Release: Reset rising mid-operation SHALL leave the machine in IDLE; no phase resumes.

Configuration
REQ-028 LOCK_TIMER_PAUSE_EN defined: the pause port exists; pause=1 freezes the prescaler, counts and state, while abort still acts; DONE is unaffected by pause.
REQ-029 LOCK_TIMER_PAUSE_EN undefined: no pause port; the timer runs continuously.

Structure
REQ-030 Package lock_timer_pkg SHALL hold the state enum and the constants ARRIVE_MAX=4, FANDP_MAX=7 and EVAC_MAX=8.
REQ-031 Sub-module lock_timer_tick SHALL implement the prescaler, with inputs clear and enable and output tick.

Verification
REQ-032 TICK_DIV=4, one-cycle start pulse -> busy=1 next cycle; countArrive=1 after 4 clocks in ARRIVE, 4 after 16; FANDP entered at 20.
REQ-033 TICK_DIV=4, full run -> done high for exactly one cycle 88 clocks after ARRIVE entry; final counts 4/7/8; then IDLE with busy=0.
REQ-034 Abort mid-FANDP with countFandP=3 -> next cycle IDLE, all counts 0, done stays 0.
REQ-035 Reset pulled low mid-EVAC with countEvacuate=5 -> all outputs 0 immediately, without a clock edge; IDLE after release.
REQ-036 start held high throughout a run -> a new run begins the cycle after DONE, with counts cleared to 0.
REQ-037 With LOCK_TIMER_PAUSE_EN, pause=1 for 10 cycles during ARRIVE -> total run length extends by exactly 10 cycles.
